// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the EX/MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_rw, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: big-endian byte array served after WAIT_CYCLES wait states,
// with a stall line to the hazard unit and a one-cycle response pulse.
module data_mem_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 CLR,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned DEPTH    = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [7:0] Mem [DEPTH];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 rw_q;
    logic [1:0]           size_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [31:0]          rsp_rdata_q;

    logic                 accept_c;
    logic                 enter_resp_c;
    logic                 err_c;
    logic                 we_c;
    logic                 eff_rw_c;
    logic [1:0]           eff_size_c;
    logic [ADDR_BITS-1:0] eff_addr_c;
    logic [31:0]          eff_wdata_c;
    logic [ADDR_BITS-1:0] idx0_c, idx1_c, idx2_c, idx3_c;
    logic [31:0]          rd_c;
    logic                 unused_addr_c;

    assign unused_addr_c = ^bus.req_addr[31:ADDR_BITS];
    assign accept_c      = bus.req_valid && (state_q == S_IDLE);

    // With zero wait states the access commits on the accept edge, so use the live inputs in IDLE.
    assign eff_rw_c    = (state_q == S_IDLE) ? bus.req_rw                       : rw_q;
    assign eff_size_c  = (state_q == S_IDLE) ? bus.req_size                     : size_q;
    assign eff_addr_c  = (state_q == S_IDLE) ? bus.req_addr[ADDR_BITS-1:0]      : addr_q;
    assign eff_wdata_c = (state_q == S_IDLE) ? bus.req_wdata                    : wdata_q;

    assign idx0_c = eff_addr_c;
    assign idx1_c = eff_addr_c + ADDR_BITS'(1);
    assign idx2_c = eff_addr_c + ADDR_BITS'(2);
    assign idx3_c = eff_addr_c + ADDR_BITS'(3);

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and access decode
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.stall     = ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_WAIT);
        enter_resp_c  = (state_d == S_RESP) && (state_q != S_RESP);
        err_c         = (eff_size_c == 2'b11)
                     || ((eff_size_c == 2'b01) && eff_addr_c[0])
                     || ((eff_size_c == 2'b10) && (eff_addr_c[1:0] != 2'b00));
        we_c          = CLR && enter_resp_c && eff_rw_c && !err_c;
        rd_c          = '0;
        unique case (eff_size_c)
            2'b00:   rd_c = {24'h0, Mem[idx0_c]};
            2'b01:   rd_c = {16'h0, Mem[idx0_c], Mem[idx1_c]};
            2'b10:   rd_c = {Mem[idx0_c], Mem[idx1_c], Mem[idx2_c], Mem[idx3_c]};
            default: rd_c = '0;
        endcase
    end

    // Request capture and response registers
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            rw_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept_c) begin
                rw_q    <= bus.req_rw;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr[ADDR_BITS-1:0];
                wdata_q <= bus.req_wdata;
            end
            rsp_valid_q <= enter_resp_c;
            rsp_err_q   <= enter_resp_c && err_c;
            if (enter_resp_c && err_c)          rsp_rdata_q <= '0;
            else if (enter_resp_c && !eff_rw_c) rsp_rdata_q <= rd_c;
        end
    end

    // Big-endian store commit; contents survive reset
    always_ff @(posedge CLK) begin
        if (we_c) begin
            unique case (eff_size_c)
                2'b00: Mem[idx0_c] <= eff_wdata_c[7:0];
                2'b01: begin
                    Mem[idx0_c] <= eff_wdata_c[15:8];
                    Mem[idx1_c] <= eff_wdata_c[7:0];
                end
                2'b10: begin
                    Mem[idx0_c] <= eff_wdata_c[31:24];
                    Mem[idx1_c] <= eff_wdata_c[23:16];
                    Mem[idx2_c] <= eff_wdata_c[15:8];
                    Mem[idx3_c] <= eff_wdata_c[7:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) share one request stream and are
// checked every cycle against an access-level model, plus hand-computed directed expectations.
module tb_data_mem_responder;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        valid, rw;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    data_mem_responder_if if0 ();
    data_mem_responder_if if1 ();

    assign if0.req_valid = valid;
    assign if0.req_rw    = rw;
    assign if0.req_size  = size;
    assign if0.req_addr  = addr;
    assign if0.req_wdata = wdata;
    assign if1.req_valid = valid;
    assign if1.req_rw    = rw;
    assign if1.req_size  = size;
    assign if1.req_addr  = addr;
    assign if1.req_wdata = wdata;

    data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut0 (.CLK(CLK), .CLR(CLR), .bus(if0));
    data_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut1 (.CLK(CLK), .CLR(CLR), .bus(if1));

    // ---------------- access-level model ----------------
    logic [7:0]  mm [2][256];
    int          last_acc [2];
    int          ecount = 0;
    logic        p_rw [2];
    logic [1:0]  p_size [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic        exp_valid [2];
    logic        exp_err [2];
    logic [31:0] exp_rdata [2];

    function automatic int wl(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic logic is_err(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00));
    endfunction

    task automatic commit(input int k);
        logic [7:0] a;
        a = p_addr[k][7:0];
        exp_valid[k] = 1'b1;
        if (is_err(p_size[k], p_addr[k])) begin
            exp_err[k]   = 1'b1;
            exp_rdata[k] = 32'h0;
        end else if (p_rw[k]) begin
            case (p_size[k])
                2'd0: mm[k][a] = p_wdata[k][7:0];
                2'd1: begin
                    mm[k][a]         = p_wdata[k][15:8];
                    mm[k][8'(a + 1)] = p_wdata[k][7:0];
                end
                default: for (int j = 0; j < 4; j++) mm[k][8'(a + j)] = 8'(p_wdata[k] >> (8 * (3 - j)));
            endcase
        end else begin
            case (p_size[k])
                2'd0:    exp_rdata[k] = {24'h0, mm[k][a]};
                2'd1:    exp_rdata[k] = {16'h0, mm[k][a], mm[k][8'(a + 1)]};
                default: exp_rdata[k] = {mm[k][a], mm[k][8'(a + 1)], mm[k][8'(a + 2)], mm[k][8'(a + 3)]};
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_acc[k]  = -1000;
            exp_valid[k] = 1'b0;
            exp_err[k]   = 1'b0;
            exp_rdata[k] = 32'h0;
            for (int i = 0; i < 256; i++) mm[k][i] = 8'h0;
        end
    end

    // A responder is free again W+2 edges after an accept; its response lands W edges after it.
    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int k = 0; k < 2; k++) begin
                last_acc[k]  = -1000;
                exp_valid[k] = 1'b0;
                exp_err[k]   = 1'b0;
                exp_rdata[k] = 32'h0;
            end
        end else begin
            ecount++;
            for (int k = 0; k < 2; k++) begin
                exp_valid[k] = 1'b0;
                exp_err[k]   = 1'b0;
                if (valid && (ecount >= last_acc[k] + wl(k) + 2)) begin
                    last_acc[k] = ecount;
                    p_rw[k]     = rw;
                    p_size[k]   = size;
                    p_addr[k]   = addr;
                    p_wdata[k]  = wdata;
                end
                if (ecount == last_acc[k] + wl(k)) commit(k);
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic busy, waiting, e_ready, e_stall;
                logic a_ready, a_stall, a_valid, a_err;
                logic [31:0] a_rdata;
                busy    = (ecount >= last_acc[k]) && (ecount <= last_acc[k] + wl(k));
                waiting = (ecount >= last_acc[k]) && (ecount <  last_acc[k] + wl(k));
                e_ready = !busy;
                e_stall = (!busy && valid) || waiting;
                a_ready = (k == 0) ? if0.req_ready : if1.req_ready;
                a_stall = (k == 0) ? if0.stall     : if1.stall;
                a_valid = (k == 0) ? if0.rsp_valid : if1.rsp_valid;
                a_err   = (k == 0) ? if0.rsp_err   : if1.rsp_err;
                a_rdata = (k == 0) ? if0.rsp_rdata : if1.rsp_rdata;
                chk("req_ready", k, 32'(a_ready), 32'(e_ready));
                chk("stall",     k, 32'(a_stall), 32'(e_stall));
                chk("rsp_valid", k, 32'(a_valid), 32'(exp_valid[k]));
                chk("rsp_err",   k, 32'(a_err),   32'(exp_err[k]));
                chk("rsp_rdata", k, a_rdata,      exp_rdata[k]);
            end
        end
    end

    // Present one request, hold it until dut0 responds, then drop valid.
    task automatic do_req(input logic r, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd0, output logic e0, output logic [31:0] rd1,
                          output logic e1, output int lat0, output int lat1);
        rw = r; size = s; addr = a; wdata = d; valid = 1'b1;
        lat0 = -1; lat1 = -1; rd0 = 32'h0; rd1 = 32'h0; e0 = 1'b0; e1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (if1.rsp_valid && (lat1 < 0)) begin
                lat1 = n; rd1 = if1.rsp_rdata; e1 = if1.rsp_err;
            end
            if (if0.rsp_valid) begin
                lat0 = n; rd0 = if0.rsp_rdata; e0 = if0.rsp_err;
                break;
            end
        end
        if (lat0 < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout dut0 actual=none required=response addr=%h", a);
        end
        @(posedge CLK); #1;
        valid = 1'b0;
    endtask

    logic [31:0] rd0, rd1;
    logic        e0, e1;
    int          lat0, lat1;

    initial begin
        valid = 1'b0; rw = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge CLK);
        #1 CLR = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_rsp_valid", 0, 32'(if0.rsp_valid), 32'h0);
        chk("rst_rsp_err",   0, 32'(if0.rsp_err),   32'h0);
        chk("rst_rsp_rdata", 0, if0.rsp_rdata,      32'h0);
        chk("rst_stall",     0, 32'(if0.stall),     32'h0);
        chk("rst_req_ready", 0, 32'(if0.req_ready), 32'h1);
        @(posedge CLK); #1;

        // Fill the whole array with known words (upper address bits random to exercise wrap)
        for (int i = 0; i < 64; i++)
            do_req(1'b1, 2'b10, {24'($urandom), 8'(i * 4)}, $urandom, rd0, e0, rd1, e1, lat0, lat1);

        do_req(1'b1, 2'b10, 32'h20, 32'hDEADBEEF, rd0, e0, rd1, e1, lat0, lat1);
        chk("st_word_err", 0, 32'(e0), 32'h0);
        chk("lat_wait2",   0, 32'(lat0), 32'd4);
        chk("lat_wait0",   1, 32'(lat1), 32'd2);
        chk("mem_20",      0, 32'(dut0.Mem[8'h20]), 32'hDE);
        do_req(1'b0, 2'b10, 32'h20, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("ld_word",     0, rd0, 32'hDEADBEEF);
        chk("ld_word",     1, rd1, 32'hDEADBEEF);
        chk("model_word",  0, exp_rdata[0], 32'hDEADBEEF);
        do_req(1'b0, 2'b00, 32'h23, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("ld_byte",     0, rd0, 32'h000000EF);
        do_req(1'b1, 2'b01, 32'h22, 32'h1234, rd0, e0, rd1, e1, lat0, lat1);
        do_req(1'b0, 2'b10, 32'h20, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("ld_after_half", 0, rd0, 32'hDEAD1234);
        chk("model_half",    0, exp_rdata[0], 32'hDEAD1234);
        do_req(1'b0, 2'b10, 32'h21, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("mis_word_err",   0, 32'(e0), 32'h1);
        chk("mis_word_rdata", 0, rd0, 32'h0);
        do_req(1'b1, 2'b10, 32'h0, 32'hA1B2C3D4, rd0, e0, rd1, e1, lat0, lat1);
        do_req(1'b1, 2'b01, 32'h1, 32'hFFFF, rd0, e0, rd1, e1, lat0, lat1);
        chk("mis_half_err", 0, 32'(e0), 32'h1);
        chk("mis_half_m1",  0, 32'(dut0.Mem[8'h01]), 32'hB2);
        chk("mis_half_m2",  0, 32'(dut0.Mem[8'h02]), 32'hC3);
        do_req(1'b0, 2'b11, 32'h40, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("rsvd_err", 0, 32'(e0), 32'h1);
        chk("rsvd_err", 1, 32'(e1), 32'h1);
        do_req(1'b1, 2'b10, 32'h0, 32'hCAFEF00D, rd0, e0, rd1, e1, lat0, lat1);
        do_req(1'b0, 2'b10, 32'h100, 32'h0, rd0, e0, rd1, e1, lat0, lat1);
        chk("wrap_ld",  0, rd0, 32'hCAFEF00D);
        chk("wrap_ld",  1, rd1, 32'hCAFEF00D);
        chk("wrap_lat", 1, 32'(lat1), 32'd2);

        // Randomised traffic; fields change only while dut0 is not stalling
        for (int c = 0; c < 600; c++) begin
            if (!if0.stall) begin
                logic [7:0] lo;
                valid = ($urandom_range(0, 3) != 0);
                rw    = $urandom_range(0, 1) == 1;
                size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                lo    = 8'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    if (size == 2'b01) lo = lo & 8'hFE;
                    if (size == 2'b10) lo = lo & 8'hFC;
                end
                addr  = {24'($urandom), lo};
                wdata = $urandom;
            end
            @(posedge CLK); #1;
        end
        valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;

        // Reset in the middle of a word store's wait states
        do_req(1'b1, 2'b10, 32'h10, 32'h11223344, rd0, e0, rd1, e1, lat0, lat1);
        rw = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'h55667788; valid = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0; valid = 1'b0;
        @(negedge CLK);
        chk("rstw_rsp_valid", 0, 32'(if0.rsp_valid), 32'h0);
        chk("rstw_stall",     0, 32'(if0.stall),     32'h0);
        chk("rstw_req_ready", 0, 32'(if0.req_ready), 32'h1);
        @(posedge CLK); #1;
        CLR = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("rstw_mem", 0, {dut0.Mem[8'h10], dut0.Mem[8'h11], dut0.Mem[8'h12], dut0.Mem[8'h13]}, 32'h11223344);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
